pe_feeder: RTL



---
 rtl/pe_pkg.sv | 18 +
 rtl/pe_feeder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the parallel_pe instruction feeder.
package pe_pkg;

    localparam int unsigned DATA_W = 512;
    localparam int unsigned INST_W = 8;

    localparam int unsigned CTL_FIRST = 0;
    localparam int unsigned CTL_LAST  = 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StStream,
        StDone
    } state_e;

endpackage

// File: rtl/pe_feeder.sv
// Instruction-driven sequencer that streams neuron/weight SRAM words into parallel_pe,
// generating beat valid and first/last control aligned with the returning read data.
module pe_feeder #(
    parameter int unsigned DATA_W  = pe_pkg::DATA_W,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INST_W  = pe_pkg::INST_W,
    parameter int unsigned INST_AW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [INST_AW:0]   inst_num,
    input  logic [ADDR_W-1:0]  n_base,
    input  logic [ADDR_W-1:0]  w_base,
    output logic               inst_re,
    output logic [INST_AW-1:0] inst_addr,
    input  logic [INST_W-1:0]  inst_rdata,
    output logic               nram_re,
    output logic [ADDR_W-1:0]  nram_addr,
    input  logic [DATA_W-1:0]  nram_rdata,
    output logic               wram_re,
    output logic [ADDR_W-1:0]  wram_addr,
    input  logic [DATA_W-1:0]  wram_rdata,
    output logic [DATA_W-1:0]  pe_neuron,
    output logic [DATA_W-1:0]  pe_weight,
    output logic [1:0]         pe_ctl,
    output logic               pe_vld_i,
    output logic               busy,
    output logic               done
);

    import pe_pkg::*;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   nptr_q, nptr_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [INST_AW:0]    num_q, num_d;
    logic [INST_AW:0]    idx_q, idx_d;
    logic [INST_AW:0]    idx_inc;
    logic [INST_W-1:0]   len_q, len_d;
    logic [INST_W-1:0]   k_q, k_d;
    logic                vld_q;
    logic [1:0]          ctl_q, ctl_d;
    logic                last_inst;
    logic                first_beat;
    logic                last_beat;

    assign idx_inc    = idx_q + 1'b1;
    assign last_inst  = (idx_inc == num_q);
    assign first_beat = (k_q == '0);
    assign last_beat  = (k_q == len_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        nptr_d    = nptr_q;
        wptr_d    = wptr_q;
        num_d     = num_q;
        idx_d     = idx_q;
        len_d     = len_q;
        k_d       = k_q;
        inst_re   = 1'b0;
        inst_addr = '0;
        nram_re   = 1'b0;
        nram_addr = '0;
        wram_re   = 1'b0;
        wram_addr = '0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_d   = inst_num;
                    nptr_d  = n_base;
                    wptr_d  = w_base;
                    idx_d   = '0;
                    state_d = (inst_num == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                inst_re   = 1'b1;
                inst_addr = idx_q[INST_AW-1:0];
                state_d   = StDecode;
            end
            StDecode: begin
                len_d = inst_rdata;
                k_d   = '0;
                // Zero-length instructions issue no beats and move straight on.
                if (inst_rdata == '0) begin
                    idx_d   = idx_inc;
                    state_d = last_inst ? StDone : StFetch;
                end else begin
                    state_d = StStream;
                end
            end
            StStream: begin
                nram_re   = 1'b1;
                wram_re   = 1'b1;
                nram_addr = nptr_q;
                wram_addr = wptr_q;
                nptr_d    = nptr_q + 1'b1;
                wptr_d    = wptr_q + 1'b1;
                if (last_beat) begin
                    idx_d   = idx_inc;
                    state_d = last_inst ? StDone : StFetch;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ctl_d = '0;
        if (state_q == StStream) begin
            ctl_d[CTL_FIRST] = first_beat;
            ctl_d[CTL_LAST]  = last_beat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            nptr_q  <= '0;
            wptr_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            k_q     <= '0;
            vld_q   <= 1'b0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            nptr_q  <= nptr_d;
            wptr_q  <= wptr_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            k_q     <= k_d;
            // Control travels one cycle behind the read so it lines up with SRAM data.
            vld_q   <= (state_q == StStream);
            ctl_q   <= ctl_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign pe_vld_i  = vld_q;
    assign pe_ctl    = ctl_q;
    assign pe_neuron = nram_rdata;
    assign pe_weight = wram_rdata;

endmodule
